// File: rtl/sim_harness_pkg.sv
// sim_harness_pkg: shared state encoding and constants for the simulation harness controller
package sim_harness_pkg;
    typedef enum logic [2:0] {ST_HOLD, ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_e;
    localparam logic [2:0] WR_NONE = 3'b000;
    localparam int PASS_SIGNATURE = 1;
    function automatic logic is_terminal(state_e s);
        return s inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
    endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-entry 8-bit synchronous FIFO
//   clk/rst      : clock, asynchronous active-low reset
//   push_i/data_i: write side; a push while full is dropped unless paired with a pop
//   pop_i/data_o : read side; data_o always shows the head entry
//   full_o/empty_o: occupancy status
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(do_push);
            rd_q  <= rd_q + PW'(do_pop);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/sim_harness_ctrl.sv
// sim_harness_ctrl: CPU reset sequencing, tohost/console snooping and watchdog for CPU benches
//   clk, rst (async, active-low)       : clock and reset
//   cpu_rst                            : active-high reset to the CPU, released RST_CYCLES after rst
//   dm_addr/dm_din/dm_wr_ctrl          : snooped data-memory write bus
//   con_valid/con_data/con_ready       : console byte stream to the bench
//   con_overflow                       : sticky, a console byte was dropped
//   done/pass/timeout/exit_code        : registered end-of-run status
//   cycle_count                        : RUN cycles elapsed (saturating)
module sim_harness_ctrl
    import sim_harness_pkg::*;
#(
    parameter int            AW           = 64,
    parameter int            DW           = 64,
    parameter logic [AW-1:0] TOHOST_ADDR  = AW'(64'h0000_1000),
    parameter logic [AW-1:0] CONSOLE_ADDR = AW'(64'h0000_1008),
    parameter int            RST_CYCLES   = 2,
    parameter int            TIMEOUT      = 100,
    parameter int            CW           = 32,
    parameter int            FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          cpu_rst,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_din,
    input  logic [2:0]    dm_wr_ctrl,
    output logic          con_valid,
    output logic [7:0]    con_data,
    input  logic          con_ready,
    output logic          con_overflow,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [DW-1:0] exit_code,
    output logic [CW-1:0] cycle_count
);
    localparam int HW = $clog2(RST_CYCLES) + 1;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [DW-1:0] exit_q, exit_d;
    logic          cpu_rst_q, cpu_rst_d, pass_q, pass_d, timeout_q, timeout_d;
    logic          done_q, done_d, ovf_q, ovf_d;
    logic          wr, tohost_end, con_push, con_pop, fifo_full, fifo_empty;
    assign wr         = dm_wr_ctrl != WR_NONE;
    // A zero written to tohost is not an exit signature and is ignored.
    assign tohost_end = wr && dm_addr == TOHOST_ADDR && dm_din != '0;
    assign con_push   = state_q == ST_RUN && wr && dm_addr == CONSOLE_ADDR;
    assign con_valid  = !fifo_empty;
    assign con_pop    = con_valid && con_ready;
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (con_push),
        .pop_i  (con_pop),
        .data_i (dm_din[7:0]),
        .data_o (con_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cpu_rst_d = cpu_rst_q;
        cyc_d     = cyc_q;
        exit_d    = exit_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        if (state_q == ST_HOLD) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(RST_CYCLES - 1)) begin
                state_d   = ST_RUN;
                cpu_rst_d = 1'b0;
            end
        end else if (state_q == ST_RUN) begin
            cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
            // A tohost end on the watchdog cycle takes priority over the timeout.
            if (tohost_end) begin
                exit_d  = dm_din >> 1;
                pass_d  = dm_din == DW'(PASS_SIGNATURE);
                state_d = pass_d ? ST_PASS : ST_FAIL;
            end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                state_d   = ST_TIMEOUT;
                timeout_d = 1'b1;
            end
        end
        ovf_d  = ovf_q || (con_push && fifo_full && !con_pop);
        // A byte pushed on this edge keeps the FIFO non-empty, so done must wait for it.
        done_d = is_terminal(state_d) && fifo_empty && !con_push;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HOLD;
            hold_q    <= '0;
            cpu_rst_q <= 1'b1;
            cyc_q     <= '0;
            exit_q    <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cpu_rst_q <= cpu_rst_d;
            cyc_q     <= cyc_d;
            exit_q    <= exit_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end
    assign cpu_rst      = cpu_rst_q;
    assign cycle_count  = cyc_q;
    assign exit_code    = exit_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign done         = done_q;
    assign con_overflow = ovf_q;
endmodule

// File: tb/tb_sim_harness_ctrl.sv
// tb_sim_harness_ctrl: randomized and directed checks of sim_harness_ctrl against a behavioural model
module tb_sim_harness_ctrl;
    localparam int          DEPTH  = 4;
    localparam int          RSTC   = 2;
    localparam int          TMO    = 100;
    localparam logic [63:0] TOHOST = 64'h1000;
    localparam logic [63:0] CON    = 64'h1008;

    logic        clk = 0, rst = 0, con_ready = 0;
    logic [63:0] dm_addr = 0, dm_din = 0;
    logic [2:0]  dm_wr_ctrl = 0;
    logic        cpu_rst, con_valid, con_overflow, done, pass, timeout;
    logic [7:0]  con_data;
    logic [63:0] exit_code;
    logic [31:0] cycle_count;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    sim_harness_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rst     (cpu_rst),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_wr_ctrl  (dm_wr_ctrl),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready),
        .con_overflow(con_overflow),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural model: run phase tracked as "edges since release", console as a queue.
    logic [7:0]  q[$];
    logic [7:0]  m_tmp;
    logic        m_cpu_rst = 1, m_run = 0, m_done = 0, m_ovf = 0;
    int          m_edges = 0, m_term = 0;   // m_term: 0 none, 1 pass, 2 fail, 3 timeout
    logic [31:0] m_cyc = 0;
    logic [63:0] m_exit = 0;
    logic        m_live, m_wr, m_push, m_pop, m_empty;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_cpu_rst = 1; m_run = 0; m_done = 0; m_ovf = 0;
            m_edges = 0; m_term = 0; m_cyc = 0; m_exit = 0;
        end else begin
            m_live  = m_run && m_term == 0;
            m_wr    = dm_wr_ctrl != 3'b000;
            m_empty = q.size() == 0;
            m_pop   = !m_empty && con_ready;
            m_push  = m_live && m_wr && dm_addr == CON;
            if (m_live) begin
                if (m_wr && dm_addr == TOHOST && dm_din != 0) begin
                    m_exit = dm_din >> 1;
                    m_term = (dm_din == 1) ? 1 : 2;
                end else if (m_cyc == TMO - 1) m_term = 3;
                if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            end else if (!m_run) begin
                m_edges++;
                if (m_edges == RSTC) begin m_run = 1; m_cpu_rst = 0; end
            end
            if (m_pop) m_tmp = q.pop_front();
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(dm_din[7:0]);
                else m_ovf = 1;
            end
            m_done = m_term != 0 && m_empty && !m_push;
        end
    end

    always @(negedge clk) begin
        chk("cpu_rst", 64'(cpu_rst), 64'(m_cpu_rst));
        chk("con_valid", 64'(con_valid), 64'(q.size() > 0));
        if (q.size() > 0) chk("con_data", 64'(con_data), 64'(q[0]));
        chk("con_overflow", 64'(con_overflow), 64'(m_ovf));
        chk("done", 64'(done), 64'(m_done));
        chk("pass", 64'(pass), 64'(m_term == 1));
        chk("timeout", 64'(timeout), 64'(m_term == 3));
        chk("exit_code", exit_code, m_exit);
        chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0; dm_wr_ctrl = 0;
        #1;
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_con_valid", 64'(con_valid), 64'd0);
        chk("rst_overflow", 64'(con_overflow), 64'd0);
        chk("rst_cycles", 64'(cycle_count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        step(2);
        #2 rst = 1;
        step(1);
        chk("hold_cpu_rst", 64'(cpu_rst), 64'd1);
        step(1);
        chk("run_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("run_cycles0", 64'(cycle_count), 64'd0);
    endtask

    task automatic wr(logic [63:0] a, logic [63:0] d);
        dm_wr_ctrl = 3'b011; dm_addr = a; dm_din = d;
        step(1);
        dm_wr_ctrl = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0] msg [5];
        msg = '{8'h48, 8'h49, 8'h21, 8'h0a, 8'h58};
        // Pass at RUN cycle 10
        do_reset();
        step(10);
        wr(TOHOST, 64'd1);
        chk("pass_pass", 64'(pass), 64'd1);
        chk("pass_done", 64'(done), 64'd1);
        chk("pass_exit", exit_code, 64'd0);
        chk("pass_cycles", 64'(cycle_count), 64'd11);
        step(5);
        chk("pass_frozen", 64'(cycle_count), 64'd11);
        // Fail with exit code 3, later tohost write ignored
        do_reset();
        step(3);
        wr(TOHOST, 64'd7);
        chk("fail_pass", 64'(pass), 64'd0);
        chk("fail_exit", exit_code, 64'd3);
        chk("fail_done", 64'(done), 64'd1);
        wr(TOHOST, 64'd1);
        chk("fail_sticky_pass", 64'(pass), 64'd0);
        chk("fail_sticky_exit", exit_code, 64'd3);
        // Watchdog
        do_reset();
        step(TMO - 1);
        chk("tmo_not_yet", 64'(timeout), 64'd0);
        step(1);
        chk("tmo_fired", 64'(timeout), 64'd1);
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_cycles", 64'(cycle_count), 64'd100);
        step(3);
        chk("tmo_frozen", 64'(cycle_count), 64'd100);
        // Tohost end on the watchdog cycle wins
        do_reset();
        step(TMO - 1);
        wr(TOHOST, 64'd1);
        chk("edge_pass", 64'(pass), 64'd1);
        chk("edge_timeout", 64'(timeout), 64'd0);
        chk("edge_cycles", 64'(cycle_count), 64'd100);
        // Console overflow and in-order drain with tohost mid-drain
        do_reset();
        con_ready = 0;
        for (int i = 0; i < 5; i++) wr(CON, {56'($urandom), msg[i]});
        chk("con_ovf", 64'(con_overflow), 64'd1);
        chk("con_head_h", 64'(con_data), 64'h48);
        con_ready = 1;
        step(1);
        chk("con_head_i", 64'(con_data), 64'h49);
        wr(TOHOST, 64'd1);
        chk("con_head_bang", 64'(con_data), 64'h21);
        chk("con_done_wait1", 64'(done), 64'd0);
        step(1);
        chk("con_head_nl", 64'(con_data), 64'h0a);
        chk("con_done_wait2", 64'(done), 64'd0);
        step(1);
        chk("con_empty", 64'(con_valid), 64'd0);
        chk("con_done_wait3", 64'(done), 64'd0);
        step(1);
        chk("con_done", 64'(done), 64'd1);
        con_ready = 0;
        // Mid-run reset with FIFO entries pending
        do_reset();
        for (int i = 0; i < 3; i++) wr(CON, 64'(msg[i]));
        step(2);
        chk("mid_valid", 64'(con_valid), 64'd1);
        do_reset();
        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 160; c++) begin
                int k;
                con_ready = (c > 120) ? 1'b1 : 1'($urandom_range(0, 1));
                k = $urandom_range(0, 19);
                dm_wr_ctrl = 0;
                dm_din = {32'($urandom), 32'($urandom)};
                dm_addr = {32'($urandom), 32'($urandom)};
                if (k < 6) begin
                    dm_wr_ctrl = 3'($urandom_range(1, 7)); dm_addr = CON;
                end else if (k == 6 && r % 3 != 0) begin
                    int t;
                    t = $urandom_range(0, 3);
                    dm_wr_ctrl = 3'($urandom_range(1, 7)); dm_addr = TOHOST;
                    if (t == 0) dm_din = 0;
                    else if (t == 1) dm_din = 1;
                end else if (k == 7) begin
                    dm_wr_ctrl = 3'($urandom_range(1, 7));
                end else if (k == 8) begin
                    dm_addr = ($urandom_range(0, 1) != 0) ? CON : TOHOST;
                end
                step(1);
            end
            dm_wr_ctrl = 0;
            chk("rand_done", 64'(done), 64'd1);
        end
        con_ready = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
